// File: rtl/sched_pkg.sv
// Shared types and helpers for the round-robin select-decoder scheduler.
package sched_pkg;

    localparam int N_REQ = 8;
    localparam int IDX_W = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        GAP   = 2'd2
    } state_t;

    // First set request at or above ptr, wrapping; scanned high-to-low so the nearest wins.
    function automatic logic [IDX_W-1:0] rr_pick(input logic [N_REQ-1:0] req,
                                                 input logic [IDX_W-1:0] ptr);
        logic [IDX_W-1:0] cand;
        logic [IDX_W-1:0] pick;
        pick = ptr;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            cand = ptr + IDX_W'(i);
            if (req[cand]) pick = cand;
        end
        return pick;
    endfunction

endpackage

// File: rtl/idx_onehot_3to8.sv
// Combinational index+enable to one-hot expander; zero latency, no flow control.
module idx_onehot_3to8
    import sched_pkg::*;
(
    input  logic [IDX_W-1:0] idx,
    input  logic             en,
    output logic [N_REQ-1:0] onehot
);

    always_comb begin
        onehot = '0;
        if (en) onehot[idx] = 1'b1;
    end

endmodule

// File: rtl/cs_round_robin_sched.sv
// Round-robin owner of a shared 3-to-8 select decoder with bounded hold and dead gap.
// Grant one cycle after req is seen in IDLE; release one cycle after done/abandon/timeout.
module cs_round_robin_sched
    import sched_pkg::*;
#(
    parameter int HOLD_MAX   = 16,
    parameter int GAP_CYCLES = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_REQ-1:0] req,
    input  logic             done,
    output logic [IDX_W-1:0] sel_idx,
    output logic             sel_en,
    output logic [N_REQ-1:0] grant,
    output logic             busy,
    output logic             timeout
);

    localparam int HOLD_W = ($clog2(HOLD_MAX + 1) < 1) ? 1 : $clog2(HOLD_MAX + 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'((HOLD_MAX == 0) ? 0 : HOLD_MAX - 1);
    localparam logic [2:0]        GAP_LAST  = 3'((GAP_CYCLES == 0) ? 0 : GAP_CYCLES - 1);

    state_t            state, state_nxt;
    logic [IDX_W-1:0]  ptr, ptr_nxt;
    logic [HOLD_W-1:0] hold_cnt, hold_nxt;
    logic [2:0]        gap_cnt, gap_nxt;
    logic [IDX_W-1:0]  idx_nxt;
    logic              en_nxt;
    logic [N_REQ-1:0]  grant_nxt;
    logic              busy_nxt;
    logic              timeout_nxt;
    logic              rel_done, rel_abandon, rel_hold;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            ptr      <= '0;
            hold_cnt <= '0;
            gap_cnt  <= '0;
            sel_idx  <= '0;
            sel_en   <= 1'b0;
            grant    <= '0;
            busy     <= 1'b0;
            timeout  <= 1'b0;
        end else begin
            state    <= state_nxt;
            ptr      <= ptr_nxt;
            hold_cnt <= hold_nxt;
            gap_cnt  <= gap_nxt;
            sel_idx  <= idx_nxt;
            sel_en   <= en_nxt;
            grant    <= grant_nxt;
            busy     <= busy_nxt;
            timeout  <= timeout_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        ptr_nxt     = ptr;
        hold_nxt    = hold_cnt;
        gap_nxt     = gap_cnt;
        idx_nxt     = sel_idx;
        en_nxt      = sel_en;
        timeout_nxt = 1'b0;
        rel_done    = 1'b0;
        rel_abandon = 1'b0;
        rel_hold    = 1'b0;

        case (state)
            IDLE: begin
                if (|req) begin
                    idx_nxt   = rr_pick(req, ptr);
                    en_nxt    = 1'b1;
                    hold_nxt  = '0;
                    state_nxt = GRANT;
                end
            end
            GRANT: begin
                rel_done    = done;
                rel_abandon = !req[sel_idx];
                rel_hold    = (HOLD_MAX != 0) && (hold_cnt == HOLD_LAST);
                if (rel_done || rel_abandon || rel_hold) begin
                    ptr_nxt     = sel_idx + 1'b1;
                    en_nxt      = 1'b0;
                    gap_nxt     = '0;
                    // Only a pure hold expiry is a revocation; an owner release wins ties.
                    timeout_nxt = !rel_done && !rel_abandon;
                    state_nxt   = (GAP_CYCLES == 0) ? IDLE : GAP;
                end else begin
                    hold_nxt = hold_cnt + 1'b1;
                end
            end
            GAP: begin
                if (gap_cnt == GAP_LAST) state_nxt = IDLE;
                else                     gap_nxt   = gap_cnt + 1'b1;
            end
            default: state_nxt = IDLE;
        endcase

        busy_nxt = (state_nxt != IDLE);
    end

    idx_onehot_3to8 u_onehot (
        .idx    (idx_nxt),
        .en     (en_nxt),
        .onehot (grant_nxt)
    );

endmodule

// File: tb/tb_cs_round_robin_sched.sv
// Directed bench for cs_round_robin_sched (HOLD_MAX=4, GAP_CYCLES=1).
module tb_cs_round_robin_sched;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic [7:0] req = 8'h00;
    logic       done = 1'b0;
    logic [2:0] sel_idx;
    logic       sel_en;
    logic [7:0] grant;
    logic       busy;
    logic       timeout;

    int checks = 0;
    int errors = 0;

    cs_round_robin_sched #(.HOLD_MAX(4), .GAP_CYCLES(1)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (req),
        .done    (done),
        .sel_idx (sel_idx),
        .sel_en  (sel_en),
        .grant   (grant),
        .busy    (busy),
        .timeout (timeout)
    );

    always #5 clk = ~clk;

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        req   = 8'h00;
        done  = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Returns number of sampled cycles with sel_en low before the grant appeared (bounded).
    task automatic wait_grant(output int waited);
        waited = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (sel_en) break;
            waited++;
        end
    endtask

    task automatic test_reset();
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({sel_idx, sel_en, grant, busy, timeout} !== 14'h0) begin
            errors++;
            $display("FAIL reset_outputs: got idx=%0d en=%b grant=%h busy=%b to=%b, expected all 0",
                     sel_idx, sel_en, grant, busy, timeout);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_single();
        int w;
        req = 8'h04;
        wait_grant(w);
        checks++;
        if (sel_idx !== 3'd2 || sel_en !== 1'b1 || grant !== 8'h04 || busy !== 1'b1 || w !== 0) begin
            errors++;
            $display("FAIL single_grant: got idx=%0d en=%b grant=%h busy=%b wait=%0d, expected 2 1 04 1 0",
                     sel_idx, sel_en, grant, busy, w);
        end
        done = 1'b1;
        @(negedge clk);
        done = 1'b0;
        req  = 8'h00;
        checks++;
        if (grant !== 8'h00 || sel_en !== 1'b0 || busy !== 1'b1 || sel_idx !== 3'd2 || timeout !== 1'b0) begin
            errors++;
            $display("FAIL single_release: got grant=%h en=%b busy=%b idx=%0d to=%b, expected 00 0 1 2 0",
                     grant, sel_en, busy, sel_idx, timeout);
        end
        @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL single_idle: got busy=%b, expected 0", busy);
        end
    endtask

    task automatic test_fairness();
        int w;
        logic [7:0] exp_g;
        do_reset();
        req = 8'hFF;
        for (int g = 0; g <= 8; g++) begin
            wait_grant(w);
            exp_g = 8'h01 << (g % 8);
            checks++;
            if (sel_idx !== 3'(g % 8) || grant !== exp_g) begin
                errors++;
                $display("FAIL rr_order[%0d]: got idx=%0d grant=%h, expected %0d %h",
                         g, sel_idx, grant, g % 8, exp_g);
            end
            if (g > 0) begin
                checks++;
                if (w + 1 !== 2) begin
                    errors++;
                    $display("FAIL rr_gap[%0d]: got %0d zero-select cycles, expected 2", g, w + 1);
                end
            end
            repeat (2) @(negedge clk);
            done = 1'b1;
            if (g == 8) req = 8'h00;
            @(negedge clk);
            done = 1'b0;
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_wrap();
        int w;
        do_reset();
        req = 8'h20;
        wait_grant(w);
        checks++;
        if (sel_idx !== 3'd5) begin
            errors++;
            $display("FAIL wrap_setup: got idx=%0d, expected 5", sel_idx);
        end
        done = 1'b1;
        req  = 8'h21;
        @(negedge clk);
        done = 1'b0;
        wait_grant(w);
        checks++;
        if (sel_idx !== 3'd0 || grant !== 8'h01) begin
            errors++;
            $display("FAIL wrap_first: got idx=%0d grant=%h, expected 0 01", sel_idx, grant);
        end
        done = 1'b1;
        @(negedge clk);
        done = 1'b0;
        wait_grant(w);
        checks++;
        if (sel_idx !== 3'd5 || grant !== 8'h20) begin
            errors++;
            $display("FAIL wrap_second: got idx=%0d grant=%h, expected 5 20", sel_idx, grant);
        end
        done = 1'b1;
        req  = 8'h00;
        @(negedge clk);
        done = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_timeout();
        int w;
        int len;
        do_reset();
        req = 8'h80;
        wait_grant(w);
        len = 1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (!sel_en) break;
            checks++;
            if (timeout !== 1'b0) begin
                errors++;
                $display("FAIL timeout_early: got timeout=1 during grant, expected 0");
            end
            len++;
        end
        checks++;
        if (len !== 4) begin
            errors++;
            $display("FAIL timeout_len: got %0d grant cycles, expected 4", len);
        end
        checks++;
        if (timeout !== 1'b1 || grant !== 8'h00) begin
            errors++;
            $display("FAIL timeout_pulse: got timeout=%b grant=%h, expected 1 00", timeout, grant);
        end
        @(negedge clk);
        checks++;
        if (timeout !== 1'b0) begin
            errors++;
            $display("FAIL timeout_once: got timeout=%b, expected 0", timeout);
        end
        wait_grant(w);
        checks++;
        if (sel_idx !== 3'd7 || grant !== 8'h80) begin
            errors++;
            $display("FAIL timeout_regrant: got idx=%0d grant=%h, expected 7 80", sel_idx, grant);
        end
        done = 1'b1;
        req  = 8'h00;
        @(negedge clk);
        done = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_abandon_collision();
        int w;
        do_reset();
        req = 8'h08;
        wait_grant(w);
        @(negedge clk);
        req = 8'h00;
        @(negedge clk);
        checks++;
        if (sel_en !== 1'b0 || grant !== 8'h00 || timeout !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL abandon: got en=%b grant=%h to=%b busy=%b, expected 0 00 0 1",
                     sel_en, grant, timeout, busy);
        end
        @(negedge clk);
        req = 8'h10;
        wait_grant(w);
        checks++;
        if (sel_idx !== 3'd4) begin
            errors++;
            $display("FAIL collision_setup: got idx=%0d, expected 4", sel_idx);
        end
        repeat (3) @(negedge clk);
        done = 1'b1;
        @(negedge clk);
        done = 1'b0;
        req  = 8'h00;
        checks++;
        if (sel_en !== 1'b0 || timeout !== 1'b0) begin
            errors++;
            $display("FAIL collision: got en=%b timeout=%b, expected 0 0", sel_en, timeout);
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_async_reset();
        int w;
        req = 8'h40;
        wait_grant(w);
        checks++;
        if (sel_idx !== 3'd6 || grant !== 8'h40) begin
            errors++;
            $display("FAIL arst_setup: got idx=%0d grant=%h, expected 6 40", sel_idx, grant);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({sel_idx, sel_en, grant, busy, timeout} !== 14'h0) begin
            errors++;
            $display("FAIL arst_clear: got idx=%0d en=%b grant=%h busy=%b to=%b, expected all 0",
                     sel_idx, sel_en, grant, busy, timeout);
        end
        @(negedge clk);
        rst_n = 1'b1;
        req   = 8'hFF;
        wait_grant(w);
        checks++;
        if (sel_idx !== 3'd0 || grant !== 8'h01) begin
            errors++;
            $display("FAIL arst_ptr: got idx=%0d grant=%h, expected 0 01", sel_idx, grant);
        end
        done = 1'b1;
        req  = 8'h00;
        @(negedge clk);
        done = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_single();
        test_fairness();
        test_wrap();
        test_timeout();
        test_abandon_collision();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
